// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline-control scheduler.
// Scheduler state encoding and PC source select codes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HZD   = 2'b01,
    MWAIT = 2'b10,
    RDIR  = 2'b11
  } sched_state_t;

  typedef enum logic [1:0] {
    PC_SEQ     = 2'b00,
    PC_PRED    = 2'b01,
    PC_CORR_T  = 2'b10,
    PC_CORR_NT = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, clr (sync clear), inc (count enable), q (value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hzd_sched.sv
// Pipeline-control scheduler: merges stalls, flushes and dmem wait.
// Ports: hazard/branch/mem inputs; stage enables, pc_sel, stats.
import pipe_ctrl_pkg::*;

module pipe_hzd_sched #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_hazard_stall,
  input  logic             ld_use_stall,
  input  logic             br_mispredict,
  input  logic             br_actual_taken,
  input  logic             br_pred_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_we,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_timeout
);

  localparam int CW = $clog2(MAX_STALL + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_STALL);

  sched_state_t state, nxt;
  pc_sel_t      psel;
  logic         pend_rdir, pend_taken;
  logic [CW-1:0] consec, consec_nxt;

  logic dmem_wait, hzd;
  logic m_rst, m_wait, m_rep, m_hzd, m_mis;

  assign dmem_wait = mem_access & ~dmem_ready;
  assign hzd       = br_hazard_stall | ld_use_stall;

  // One-hot mode decode in priority order.
  // A pending redirect only exists after a freeze,
  // so it replays on the first MWAIT cycle that resumes.
  assign m_rst  = ~rst_n;
  assign m_wait = rst_n & dmem_wait;
  assign m_rep  = rst_n & ~dmem_wait & pend_rdir &
                  ((state == MWAIT) | (state == RDIR));
  assign m_hzd  = rst_n & ~dmem_wait & ~m_rep & hzd;
  assign m_mis  = rst_n & ~dmem_wait & ~m_rep & ~hzd &
                  br_mispredict;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    pipe_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    psel        = br_pred_taken ? PC_PRED : PC_SEQ;
    nxt         = RUN;
    unique case (1'b1)
      m_rst: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        pipe_we     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        psel        = PC_SEQ;
      end
      m_wait: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        pipe_we = 1'b0;
        psel    = PC_SEQ;
        nxt     = MWAIT;
      end
      m_rep: begin
        ifid_flush = 1'b1;
        psel       = pend_taken ? PC_CORR_T : PC_CORR_NT;
      end
      m_hzd: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        psel        = PC_SEQ;
        nxt         = HZD;
      end
      m_mis: begin
        ifid_flush = 1'b1;
        psel = br_actual_taken ? PC_CORR_T : PC_CORR_NT;
      end
      default: ;
    endcase
  end

  assign pc_sel = psel;

  assign consec_nxt = (consec == MAXC) ? consec
                                       : consec + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      pend_rdir     <= 1'b0;
      pend_taken    <= 1'b0;
      consec        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state <= nxt;
      // First redirect seen during a freeze wins.
      if (m_wait && br_mispredict && !pend_rdir) begin
        pend_rdir  <= 1'b1;
        pend_taken <= br_actual_taken;
      end else if (m_rep) begin
        pend_rdir <= 1'b0;
      end
      // Freeze cycles neither extend nor break a stall run.
      if (m_hzd) begin
        consec <= consec_nxt;
        if (consec_nxt == MAXC) stall_timeout <= 1'b1;
      end else if (!dmem_wait) begin
        consec <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (m_rst),
    .inc (m_hzd),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (m_rst),
    .inc (m_rep | m_mis),
    .q   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hzd_sched.sv
// Scoreboard bench for pipe_hzd_sched with a behavioural model.
// Directed test-plan sequences followed by random traffic.
module tb_pipe_hzd_sched;

  localparam int CNT_W     = 4;
  localparam int MAX_STALL = 8;
  localparam int CMAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_we;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             stall_timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bhs = 1'b0, lus = 1'b0, mis = 1'b0, act = 1'b0;
  logic pred = 1'b0, ma = 1'b0, rdy = 1'b0;

  logic             pc_we, ifid_we, ifid_flush;
  logic             idex_bubble, pipe_we, stall_timeout;
  logic [1:0]       pc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t q[$];

  // reference state
  bit m_pend = 0, m_ptaken = 0, m_tout = 0;
  int m_scnt = 0, m_fcnt = 0, m_run = 0;

  always #5 clk = ~clk;

  pipe_hzd_sched #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .br_hazard_stall (bhs),
    .ld_use_stall    (lus),
    .br_mispredict   (mis),
    .br_actual_taken (act),
    .br_pred_taken   (pred),
    .mem_access      (ma),
    .dmem_ready      (rdy),
    .pc_we           (pc_we),
    .ifid_we         (ifid_we),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .pipe_we         (pipe_we),
    .pc_sel          (pc_sel),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .stall_timeout   (stall_timeout)
  );

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Expected response for this cycle, then advance the model.
  function automatic exp_t model_step();
    exp_t e;
    bit frz, stl;
    frz = ma && !rdy;
    stl = bhs || lus;
    e.stall_cnt     = CNT_W'(m_scnt);
    e.flush_cnt     = CNT_W'(m_fcnt);
    e.stall_timeout = m_tout;
    e.ifid_flush    = 0;
    e.idex_bubble   = 0;
    e.pc_sel        = 2'd0;
    if (!rst_n) begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b000;
      e.ifid_flush  = 1;
      e.idex_bubble = 1;
      m_pend = 0; m_ptaken = 0; m_tout = 0;
      m_scnt = 0; m_fcnt = 0; m_run = 0;
    end else if (frz) begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b000;
      if (mis && !m_pend) begin
        m_pend   = 1;
        m_ptaken = act;
      end
    end else if (m_pend) begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b111;
      e.ifid_flush = 1;
      e.pc_sel = m_ptaken ? 2'd2 : 2'd3;
      m_pend = 0;
      m_fcnt = sat(m_fcnt);
      m_run  = 0;
    end else if (stl) begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b001;
      e.idex_bubble = 1;
      m_scnt = sat(m_scnt);
      if (m_run < MAX_STALL) m_run++;
      if (m_run == MAX_STALL) m_tout = 1;
    end else if (mis) begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b111;
      e.ifid_flush = 1;
      e.pc_sel = act ? 2'd2 : 2'd3;
      m_fcnt = sat(m_fcnt);
      m_run  = 0;
    end else begin
      {e.pc_we, e.ifid_we, e.pipe_we} = 3'b111;
      e.pc_sel = pred ? 2'd1 : 2'd0;
      m_run = 0;
    end
    return e;
  endfunction

  // rst, bhs, lus, mis, act, pred, ma, rdy
  task automatic drive(input logic [7:0] v, input bit chk = 1);
    @(posedge clk);
    #1;
    {rst_n, bhs, lus, mis, act, pred, ma, rdy} = v;
    cyc++;
    if (chk) q.push_back(model_step());
  endtask

  always @(negedge clk) begin
    exp_t a, e;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_we,
           pc_sel, stall_cnt, flush_cnt, stall_timeout};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc%0d: got %b want %b", cyc, a, e);
      end
    end
  end

  initial begin
    // first reset cycle: register contents not yet known
    drive(8'b0000_0000, 0);
    drive(8'b0000_0000);
    // normal, pred taken on 3rd
    drive(8'b1000_0000);
    drive(8'b1000_0000);
    drive(8'b1000_0100);
    drive(8'b1000_0000);
    drive(8'b1000_0000);
    // load-use stall with mispredict ignored
    drive(8'b1011_0000);
    drive(8'b1011_0000);
    drive(8'b1000_0000);
    // mispredict not-taken in RUN
    drive(8'b1001_0000);
    drive(8'b1000_0000);
    // memory freeze, mispredict taken in 2nd cycle
    drive(8'b1000_0010);
    drive(8'b1001_1010);
    drive(8'b1001_0010);
    drive(8'b1000_0011);
    drive(8'b1000_0000);
    // hazard stall for 10 cycles trips watchdog
    repeat (10) drive(8'b1100_0000);
    drive(8'b1000_0000);
    drive(8'b1000_0000);
    // reset mid-stall with a redirect pending
    drive(8'b1100_0000);
    drive(8'b1101_1010);
    drive(8'b0100_0010);
    drive(8'b1000_0000);
    drive(8'b1000_0000);
    // random traffic, long enough to saturate counters
    repeat (600) begin
      logic [7:0] v;
      v[7] = ($urandom_range(0, 99) != 0);
      v[6] = ($urandom_range(0, 3) == 0);
      v[5] = ($urandom_range(0, 5) == 0);
      v[4] = ($urandom_range(0, 3) == 0);
      v[3] = 1'($urandom);
      v[2] = 1'($urandom);
      v[1] = ($urandom_range(0, 2) == 0);
      v[0] = ($urandom_range(0, 2) != 0);
      drive(v);
    end
    // long stall run for saturation and watchdog
    repeat (20) drive(8'b1010_0000);
    drive(8'b1000_0000);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
